// File: rtl/mesi_coherency_ctrl.sv
// Per-core MESI coherence controller: arbitrates L1 misses, upgrades and writebacks against
// bus snoops (snoops first), pre-empting and later resuming an in-flight request.
module mesi_coherency_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned N_SETS     = 16,
  parameter int unsigned CPUID      = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                CLK,
  input  logic                                nRST,
  // cache request side
  input  logic                                req_ren,
  input  logic                                req_wen,
  input  logic                                req_upg,
  input  logic                                req_wb,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [BLOCK_SIZE*32-1:0]            req_wdata,
  output logic                                req_busy,
  output logic                                fill_valid,
  output logic [BLOCK_SIZE*32-1:0]            fill_data,
  output logic [1:0]                          fill_state,
  // bus controller side
  output logic                                bus_dREN,
  output logic                                bus_dWEN,
  output logic                                bus_ccwrite,
  output logic [ADDR_WIDTH-1:0]               bus_daddr,
  output logic [BLOCK_SIZE*32-1:0]            bus_dstore,
  input  logic [BLOCK_SIZE*32-1:0]            bus_dload,
  input  logic                                bus_dwait,
  input  logic                                bus_ccexclusive,
  input  logic                                bus_ccwait,
  input  logic                                bus_ccinv,
  input  logic [ADDR_WIDTH-1:0]               bus_ccsnoopaddr,
  output logic                                bus_ccsnoopdone,
  output logic                                bus_ccsnoophit,
  output logic                                bus_ccdirty,
  // snoop port to the cache tag array
  output logic                                snp_req,
  output logic [$clog2(N_SETS)-1:0]           snp_set,
  output logic [ADDR_WIDTH-1:0]               snp_tag,
  input  logic                                snp_hit,
  input  logic                                snp_dirty,
  input  logic [BLOCK_SIZE*32-1:0]            snp_data,
  output logic                                snp_update,
  output logic [1:0]                          snp_new_state,
  output logic [CNT_WIDTH-1:0]                snoop_hit_count
);

  localparam int unsigned DATA_W = BLOCK_SIZE * 32;
  localparam int unsigned OFF    = 2 + $clog2(BLOCK_SIZE);
  localparam int unsigned SET_W  = $clog2(N_SETS);

  localparam logic [1:0] MESI_M = 2'd0;
  localparam logic [1:0] MESI_E = 2'd1;
  localparam logic [1:0] MESI_S = 2'd2;
  localparam logic [1:0] MESI_I = 2'd3;

  // Elaboration-time sanity on the geometry parameters
  if ((BLOCK_SIZE == 0) || ((BLOCK_SIZE & (BLOCK_SIZE - 1)) != 0)) begin : g_bad_block
    $error("BLOCK_SIZE must be a power of two");
  end
  if ((N_SETS < 2) || ((N_SETS & (N_SETS - 1)) != 0)) begin : g_bad_sets
    $error("N_SETS must be a power of two >= 2");
  end
  if (CPUID > 65535) begin : g_bad_cpuid
    $error("CPUID out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SNP_LOOKUP, S_SNP_SEND, S_REQ_RD, S_REQ_RFO, S_REQ_UPG, S_REQ_WB, S_DONE
  } state_e;

  typedef enum logic [1:0] {K_RD, K_RFO, K_UPG, K_WB} kind_e;

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic                  lat_valid_q, lat_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     fill_data_q, fill_data_d;
  logic [1:0]            fill_state_q, fill_state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     snp_data_q, snp_data_d;
  logic                  snp_dirty_q, snp_dirty_d;
  logic                  snp_inv_q, snp_inv_d;

  logic  any_req;
  kind_e new_kind;
  logic  blk_match;

  function automatic state_e kind_state(input kind_e k);
    case (k)
      K_RD:    return S_REQ_RD;
      K_RFO:   return S_REQ_RFO;
      K_UPG:   return S_REQ_UPG;
      default: return S_REQ_WB;
    endcase
  endfunction

  // Fixed request priority: writeback > RFO > upgrade > read
  always_comb begin
    any_req  = req_wb | req_wen | req_upg | req_ren;
    new_kind = K_RD;
    if (req_wb)       new_kind = K_WB;
    else if (req_wen) new_kind = K_RFO;
    else if (req_upg) new_kind = K_UPG;
    blk_match = (addr_q[ADDR_WIDTH-1:OFF] == bus_ccsnoopaddr[ADDR_WIDTH-1:OFF]);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      kind_q       <= K_RD;
      lat_valid_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_data_q  <= '0;
      fill_state_q <= MESI_I;
      cnt_q        <= '0;
      snp_data_q   <= '0;
      snp_dirty_q  <= 1'b0;
      snp_inv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      lat_valid_q  <= lat_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      fill_data_q  <= fill_data_d;
      fill_state_q <= fill_state_d;
      cnt_q        <= cnt_d;
      snp_data_q   <= snp_data_d;
      snp_dirty_q  <= snp_dirty_d;
      snp_inv_q    <= snp_inv_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    lat_valid_d     = lat_valid_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    fill_data_d     = fill_data_q;
    fill_state_d    = fill_state_q;
    cnt_d           = cnt_q;
    snp_data_d      = snp_data_q;
    snp_dirty_d     = snp_dirty_q;
    snp_inv_d       = snp_inv_q;
    fill_valid      = 1'b0;
    bus_dREN        = 1'b0;
    bus_dWEN        = 1'b0;
    bus_ccwrite     = 1'b0;
    bus_daddr       = '0;
    bus_dstore      = '0;
    bus_ccsnoopdone = 1'b0;
    bus_ccsnoophit  = 1'b0;
    bus_ccdirty     = 1'b0;
    snp_req         = 1'b0;
    snp_set         = '0;
    snp_tag         = '0;
    snp_update      = 1'b0;
    snp_new_state   = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (bus_ccwait) begin
          state_d = S_SNP_LOOKUP;
        end else if (any_req) begin
          lat_valid_d = 1'b1;
          kind_d      = new_kind;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          state_d     = kind_state(new_kind);
        end
      end

      S_SNP_LOOKUP: begin
        snp_req         = 1'b1;
        snp_set         = bus_ccsnoopaddr[OFF +: SET_W];
        snp_tag         = bus_ccsnoopaddr;
        bus_ccsnoopdone = 1'b1;
        bus_ccsnoophit  = snp_hit;
        snp_data_d      = snp_data;
        snp_dirty_d     = snp_dirty;
        snp_inv_d       = bus_ccinv;
        // A pending upgrade loses its shared copy when the snoop invalidates it
        if (lat_valid_q && (kind_q == K_UPG) && bus_ccinv && blk_match) begin
          kind_d = K_RFO;
        end
        if (snp_hit)          state_d = S_SNP_SEND;
        else if (lat_valid_q) state_d = kind_state(kind_d);
        else                  state_d = S_IDLE;
      end

      S_SNP_SEND: begin
        bus_dstore     = snp_data_q;
        bus_ccsnoophit = 1'b1;
        bus_ccdirty    = snp_dirty_q;
        snp_new_state  = snp_inv_q ? MESI_I : MESI_S;
        if (!bus_ccwait) begin
          snp_update = 1'b1;
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
          state_d = lat_valid_q ? kind_state(kind_q) : S_IDLE;
        end
      end

      S_REQ_RD, S_REQ_RFO, S_REQ_UPG, S_REQ_WB: begin
        bus_daddr   = addr_q;
        bus_dREN    = (state_q == S_REQ_RD);
        bus_dWEN    = (state_q == S_REQ_WB);
        bus_ccwrite = (state_q == S_REQ_RFO) || (state_q == S_REQ_UPG);
        if (state_q == S_REQ_WB) bus_dstore = wdata_q;
        if (!bus_dwait) begin
          state_d     = S_DONE;
          fill_data_d = bus_dload;
          case (state_q)
            S_REQ_RD: fill_state_d = bus_ccexclusive ? MESI_E : MESI_S;
            S_REQ_WB: fill_state_d = MESI_I;
            default:  fill_state_d = MESI_M;
          endcase
        end else if (bus_ccwait) begin
          state_d = S_SNP_LOOKUP;
        end
      end

      S_DONE: begin
        fill_valid  = 1'b1;
        lat_valid_d = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_busy        = any_req | (lat_valid_q & (state_q != S_DONE));
  assign fill_data       = fill_data_q;
  assign fill_state      = fill_state_q;
  assign snoop_hit_count = cnt_q;

endmodule

// File: tb/tb_mesi_coherency_ctrl.sv
// Directed bench for mesi_coherency_ctrl: reads, snoops, pre-emption, priority, saturation, reset.
module tb_mesi_coherency_ctrl;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 2;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          req_ren, req_wen, req_upg, req_wb;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_busy, fill_valid;
  logic [DW-1:0] fill_data;
  logic [1:0]    fill_state;
  logic          bus_dREN, bus_dWEN, bus_ccwrite;
  logic [AW-1:0] bus_daddr;
  logic [DW-1:0] bus_dstore, bus_dload;
  logic          bus_dwait, bus_ccexclusive, bus_ccwait, bus_ccinv;
  logic [AW-1:0] bus_ccsnoopaddr;
  logic          bus_ccsnoopdone, bus_ccsnoophit, bus_ccdirty;
  logic          snp_req;
  logic [3:0]    snp_set;
  logic [AW-1:0] snp_tag;
  logic          snp_hit, snp_dirty;
  logic [DW-1:0] snp_data;
  logic          snp_update;
  logic [1:0]    snp_new_state;
  logic [CW-1:0] snoop_hit_count;

  int n_cmp = 0;
  int n_err = 0;

  mesi_coherency_ctrl #(.ADDR_WIDTH(AW), .BLOCK_SIZE(2), .N_SETS(16), .CPUID(0), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_upg(req_upg), .req_wb(req_wb),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_busy(req_busy),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_state(fill_state),
    .bus_dREN(bus_dREN), .bus_dWEN(bus_dWEN), .bus_ccwrite(bus_ccwrite),
    .bus_daddr(bus_daddr), .bus_dstore(bus_dstore), .bus_dload(bus_dload),
    .bus_dwait(bus_dwait), .bus_ccexclusive(bus_ccexclusive), .bus_ccwait(bus_ccwait),
    .bus_ccinv(bus_ccinv), .bus_ccsnoopaddr(bus_ccsnoopaddr),
    .bus_ccsnoopdone(bus_ccsnoopdone), .bus_ccsnoophit(bus_ccsnoophit), .bus_ccdirty(bus_ccdirty),
    .snp_req(snp_req), .snp_set(snp_set), .snp_tag(snp_tag),
    .snp_hit(snp_hit), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .snp_update(snp_update), .snp_new_state(snp_new_state),
    .snoop_hit_count(snoop_hit_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One snoop from IDLE or a pre-empted request; returns one cycle after the snoop ends
  task automatic snoop(input string tag, input logic [AW-1:0] a, input logic inv, input logic hit,
                       input logic dirty, input logic [DW-1:0] d, input logic [CW-1:0] exp_cnt);
    logic [3:0] exp_set;
    exp_set = a[6:3];
    bus_ccwait = 1'b1; bus_ccinv = inv; bus_ccsnoopaddr = a;
    snp_hit = hit; snp_dirty = dirty; snp_data = d;
    tick();
    chk({tag, ".snp_req"}, snp_req, 1);
    chk({tag, ".snoopdone"}, bus_ccsnoopdone, 1);
    chk({tag, ".lookup_hit"}, bus_ccsnoophit, hit);
    chk({tag, ".snp_set"}, snp_set, exp_set);
    chk({tag, ".snp_tag"}, snp_tag, a);
    chk({tag, ".no_cmd"}, {bus_dREN, bus_dWEN, bus_ccwrite}, 0);
    if (!hit) bus_ccwait = 1'b0;
    tick();
    if (hit) begin
      chk({tag, ".send_hit"}, bus_ccsnoophit, 1);
      chk({tag, ".send_dirty"}, bus_ccdirty, dirty);
      chk({tag, ".send_data"}, bus_dstore, d);
      chk({tag, ".upd_held"}, snp_update, 0);
      bus_ccwait = 1'b0;
      #1;
      chk({tag, ".upd_pulse"}, snp_update, 1);
      chk({tag, ".new_state"}, snp_new_state, inv ? 2'd3 : 2'd2);
      tick();
      chk({tag, ".upd_end"}, snp_update, 0);
    end
    chk({tag, ".count"}, snoop_hit_count, exp_cnt);
    snp_hit = 1'b0; snp_dirty = 1'b0; bus_ccinv = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    req_ren = 0; req_wen = 0; req_upg = 0; req_wb = 0;
    req_addr = '0; req_wdata = '0; bus_dload = '0; bus_dwait = 0;
    bus_ccexclusive = 0; bus_ccwait = 0; bus_ccinv = 0; bus_ccsnoopaddr = '0;
    snp_hit = 0; snp_dirty = 0; snp_data = '0;
    tick(); tick();
    chk("rst.busy", req_busy, 0);
    chk("rst.fill_valid", fill_valid, 0);
    chk("rst.fill_state", fill_state, 3);
    chk("rst.cmd", {bus_dREN, bus_dWEN, bus_ccwrite}, 0);
    chk("rst.count", snoop_hit_count, 0);
    nRST = 1'b1;
    tick();

    // Read miss 0x100, dwait high two cycles then low: three dREN cycles, exclusive -> E
    req_ren = 1; req_addr = 32'h100; bus_dwait = 1;
    tick();
    req_ren = 0; req_addr = 32'hDEAD0;
    for (int k = 0; k < 3; k++) begin
      bus_dwait = (k < 2);
      if (k == 2) begin bus_dload = 64'h1111_2222_3333_4444; bus_ccexclusive = 1; end
      #1;
      chk("rd.dREN", bus_dREN, 1);
      chk("rd.daddr", bus_daddr, 32'h100);
      chk("rd.busy", req_busy, 1);
      tick();
    end
    bus_ccexclusive = 0;
    chk("rd.fill_valid", fill_valid, 1);
    chk("rd.fill_state", fill_state, 1);
    chk("rd.fill_data", fill_data, 64'h1111_2222_3333_4444);
    chk("rd.dREN_off", bus_dREN, 0);
    tick();
    chk("rd.fill_end", fill_valid, 0);
    chk("rd.idle_busy", req_busy, 0);

    // Invalidating snoop hits a dirty block
    snoop("snp1", 32'h200, 1, 1, 1, 64'hAAAA_BBBB_CCCC_DDDD, 2'd1);

    // Upgrade pre-empted by an invalidating snoop on its own block resumes as RFO
    req_upg = 1; req_addr = 32'h300; bus_dwait = 1;
    tick();
    req_upg = 0; #1;
    chk("upg.ccwrite", bus_ccwrite, 1);
    chk("upg.dren", {bus_dREN, bus_dWEN}, 0);
    chk("upg.dstore", bus_dstore, 0);
    chk("upg.daddr", bus_daddr, 32'h300);
    snoop("upg_snp", 32'h300, 1, 1, 0, 64'h5555_6666_7777_8888, 2'd2);
    chk("upg.resume_ccwrite", bus_ccwrite, 1);
    chk("upg.resume_daddr", bus_daddr, 32'h300);
    chk("upg.resume_busy", req_busy, 1);
    bus_dwait = 0; bus_dload = 64'h0123_4567_89AB_CDEF;
    tick();
    chk("upg.fill_valid", fill_valid, 1);
    chk("upg.fill_state", fill_state, 0);
    chk("upg.fill_data", fill_data, 64'h0123_4567_89AB_CDEF);
    tick();

    // Snoop and read arrive together in IDLE: snoop (miss) first, then the read
    req_ren = 1; req_addr = 32'h700; bus_dwait = 1;
    snoop("race_snp", 32'h700, 0, 0, 0, 64'h0, 2'd2);
    chk("race.busy", req_busy, 1);
    chk("race.dREN_idle", bus_dREN, 0);
    tick();
    chk("race.dREN", bus_dREN, 1);
    chk("race.daddr", bus_daddr, 32'h700);
    req_ren = 0; bus_dwait = 0; bus_dload = 64'hFEED_0000_0000_0003;
    tick();
    chk("race.fill_state", fill_state, 2);
    tick();

    // Writeback and read in the same cycle: writeback first, then the read
    req_wb = 1; req_ren = 1; req_addr = 32'h400; req_wdata = 64'hC0FF_EE00_1234_5678; bus_dwait = 1;
    tick();
    req_wb = 0; req_addr = 32'h500; #1;
    chk("wb.dWEN", bus_dWEN, 1);
    chk("wb.dREN", bus_dREN, 0);
    chk("wb.dstore", bus_dstore, 64'hC0FF_EE00_1234_5678);
    chk("wb.daddr", bus_daddr, 32'h400);
    bus_dwait = 0;
    tick();
    chk("wb.fill_valid", fill_valid, 1);
    chk("wb.fill_state", fill_state, 3);
    chk("wb.busy", req_busy, 1);
    tick();
    chk("wb.gap_fill", fill_valid, 0);
    tick();
    chk("wb2.dREN", bus_dREN, 1);
    chk("wb2.dWEN", bus_dWEN, 0);
    chk("wb2.daddr", bus_daddr, 32'h500);
    req_ren = 0; bus_dload = 64'h9999_8888_7777_6666;
    tick();
    chk("wb2.fill_valid", fill_valid, 1);
    chk("wb2.fill_state", fill_state, 2);
    chk("wb2.fill_data", fill_data, 64'h9999_8888_7777_6666);
    tick();

    // Counter saturates at all-ones
    snoop("sat1", 32'h238, 0, 1, 0, 64'h1234, 2'd3);
    snoop("sat2", 32'h240, 0, 1, 1, 64'h5678, 2'd3);

    // Reset in the middle of an RFO aborts with no fill pulse
    req_wen = 1; req_addr = 32'h600; bus_dwait = 1;
    tick();
    req_wen = 0; #1;
    chk("rfo.ccwrite", bus_ccwrite, 1);
    nRST = 0;
    tick();
    chk("rfo_rst.ccwrite", bus_ccwrite, 0);
    chk("rfo_rst.busy", req_busy, 0);
    chk("rfo_rst.fill_valid", fill_valid, 0);
    chk("rfo_rst.fill_state", fill_state, 3);
    chk("rfo_rst.daddr", bus_daddr, 0);
    chk("rfo_rst.count", snoop_hit_count, 0);
    nRST = 1; bus_dwait = 0;
    tick();
    chk("rfo_rst.no_fill1", fill_valid, 0);
    tick();
    chk("rfo_rst.no_fill2", fill_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
